// File: rtl/satd_accumulator.sv
// satd_accumulator
//   Consumes the column-Hadamard output of the SATD engine and produces one
//   sum-of-absolute-transformed-differences value per 8x8 block.
//   Each row goes through abs -> 8-input adder tree -> 8-row accumulation,
//   and the final sum is normalized with rounding.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   stage       sequencer stage (0..3); row data is present only in stage 2
//   count       sequencer row index 0..7 within the stage
//   coef_in     8 two's-complement coefficients, lane i at [COEF_W*(i+1)-1 : COEF_W*i]
//   satd_out    normalized block SATD, held until the next result
//   satd_valid  one-cycle pulse marking a new satd_out
//   busy        a block is in flight (input FSM in ACCUM or a pipeline stage valid)
//   seq_err     one-cycle pulse, one cycle after a row-sequence violation
//   dbg_state   input FSM state (0 = IDLE, 1 = ACCUM)
//
// Interface contract: a row is valid exactly when stage==2; there is no
// ready/backpressure, so every stage-2 cycle is either accepted or rejected
// (with seq_err) in that same cycle. satd_valid is a single-cycle strobe with
// no acknowledge.
//
// ACC_W must be at least COEF_W+6 so 64 full-scale magnitudes cannot overflow.

module satd_accumulator #(
    parameter int COEF_W     = 16,
    parameter int ACC_W      = 22,
    parameter int NORM_SHIFT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          stage,
    input  logic [2:0]          count,
    input  logic [8*COEF_W-1:0] coef_in,
    output logic [ACC_W-1:0]    satd_out,
    output logic                satd_valid,
    output logic                busy,
    output logic                seq_err,
    output logic                dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam int SUM_W = COEF_W + 3;
    localparam logic [COEF_W-1:0] ONE_C = COEF_W'(1);
    // Half an output LSB; zero when no shift is applied.
    localparam logic [ACC_W:0] ROUND = (ACC_W+1)'((1 << NORM_SHIFT) >> 1);

    // Input FSM
    state_t      state_q, state_d;
    logic [2:0]  row_cnt_q, row_cnt_d;
    logic        seq_err_q, seq_err_d;
    logic        accept, tag_first, tag_last, abort;
    logic        is_row;

    // S1: per-lane magnitudes
    logic              s1_valid_q, s1_valid_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_last_q,  s1_last_d;
    logic [COEF_W-1:0] s1_abs_q [8];
    logic [COEF_W-1:0] s1_abs_d [8];
    logic [COEF_W-1:0] lane     [8];

    // S2: row sum
    logic             s2_valid_q, s2_valid_d;
    logic             s2_first_q, s2_first_d;
    logic             s2_last_q,  s2_last_d;
    logic [SUM_W-1:0] s2_sum_q,   s2_sum_d;

    // S3: accumulator and result
    logic             s3_en;
    logic [ACC_W-1:0] acc_q, acc_d, acc_next;
    logic [ACC_W:0]   rounded;
    logic [ACC_W-1:0] satd_out_q, satd_out_d;
    logic             satd_valid_q, satd_valid_d;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        seq_err_d = 1'b0;
        accept    = 1'b0;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        abort     = 1'b0;
        is_row    = (stage == 2'd2);
        case (state_q)
            S_IDLE: begin
                if (is_row) begin
                    if (count == 3'd0) begin
                        accept    = 1'b1;
                        tag_first = 1'b1;
                        row_cnt_d = 3'd1;
                        state_d   = S_ACCUM;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end
            S_ACCUM: begin
                if (is_row && (count == row_cnt_q)) begin
                    accept    = 1'b1;
                    row_cnt_d = row_cnt_q + 3'd1;
                    if (count == 3'd7) begin
                        tag_last  = 1'b1;
                        row_cnt_d = 3'd0;
                        state_d   = S_IDLE;
                    end
                end else begin
                    abort     = 1'b1;
                    seq_err_d = 1'b1;
                    // A violating row that is itself a row 0 restarts the block.
                    if (is_row && (count == 3'd0)) begin
                        accept    = 1'b1;
                        tag_first = 1'b1;
                        row_cnt_d = 3'd1;
                    end else begin
                        row_cnt_d = 3'd0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                row_cnt_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = accept;
        s1_first_d = tag_first;
        s1_last_d  = tag_last;
        for (int i = 0; i < 8; i++) begin
            lane[i] = coef_in[i*COEF_W +: COEF_W];
            // Unsigned result, so the most negative input maps to 2^(COEF_W-1).
            s1_abs_d[i] = lane[i][COEF_W-1] ? (~lane[i] + ONE_C) : lane[i];
        end
    end

    // On abort, the S1 row always belongs to the aborted block. The S2 row
    // belongs to it too unless it is the previous block's last row, which
    // must still complete.
    always_comb begin
        s2_valid_d = s1_valid_q && !abort;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_sum_d   = '0;
        for (int i = 0; i < 8; i++) begin
            s2_sum_d = s2_sum_d + {3'b000, s1_abs_q[i]};
        end
    end

    always_comb begin
        s3_en        = s2_valid_q && !(abort && !s2_last_q);
        acc_next     = (s2_first_q ? '0 : acc_q) + {{(ACC_W-SUM_W){1'b0}}, s2_sum_q};
        acc_d        = s3_en ? acc_next : acc_q;
        rounded      = {1'b0, acc_next} + ROUND;
        satd_valid_d = s3_en && s2_last_q;
        satd_out_d   = satd_valid_d ? ACC_W'(rounded >> NORM_SHIFT) : satd_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            row_cnt_q    <= '0;
            seq_err_q    <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            for (int i = 0; i < 8; i++) s1_abs_q[i] <= '0;
            s2_valid_q   <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_sum_q     <= '0;
            acc_q        <= '0;
            satd_out_q   <= '0;
            satd_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            seq_err_q    <= seq_err_d;
            s1_valid_q   <= s1_valid_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            for (int i = 0; i < 8; i++) s1_abs_q[i] <= s1_abs_d[i];
            s2_valid_q   <= s2_valid_d;
            s2_first_q   <= s2_first_d;
            s2_last_q    <= s2_last_d;
            s2_sum_q     <= s2_sum_d;
            acc_q        <= acc_d;
            satd_out_q   <= satd_out_d;
            satd_valid_q <= satd_valid_d;
        end
    end

    assign satd_out   = satd_out_q;
    assign satd_valid = satd_valid_q;
    assign seq_err    = seq_err_q;
    assign busy       = (state_q == S_ACCUM) || s1_valid_q || s2_valid_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/satd_accumulator.md
Name: satd_accumulator

Overview:
- Datapath consumer that sits directly downstream of the SATD control sequencer (stage/count FSM) and the column Hadamard transform.
- During stage 2, one row of 8 transformed coefficients arrives per cycle.
- Pipeline: absolute value, 8-input adder tree, 8-row accumulation, then rounding normalization.
- Emits one SATD value per 8x8 block as a single-cycle valid pulse.

Parameters:
- COEF_W, 16, signed width of each transformed coefficient.
- ACC_W, 22, accumulator and output width; must be at least COEF_W+6.
- NORM_SHIFT, 2, right shift applied to the final sum; rounding term is 1<<(NORM_SHIFT-1) when NORM_SHIFT>0, otherwise 0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stage  in  2  sequencer stage (0..3); a row is presented only when stage==2.
- count  in  3  sequencer row index 0..7 within the stage.
- coef_in  in  8*COEF_W  coefficient i on bits [COEF_W*(i+1)-1 : COEF_W*i], two's complement.
- satd_out  out  ACC_W  normalized block SATD; held until the next result.
- satd_valid  out  1  one-cycle pulse; satd_out is new this cycle.
- busy  out  1  high while a block is in flight (input FSM in ACCUM or any pipeline stage valid).
- seq_err  out  1  one-cycle pulse on a row-sequence violation.

Behaviour:
- Reset: satd_out=0, satd_valid=0, busy=0, seq_err=0. Pipeline valids, accumulator and row_cnt are cleared; input FSM goes to IDLE. Reset at any point aborts an in-flight block, and no satd_valid is produced for it.
- Input FSM states: IDLE and ACCUM, with a 3-bit row_cnt.
  - IDLE, stage==2 and count==0: accept the row tagged first; row_cnt=1; go to ACCUM.
  - IDLE, stage==2 and count!=0: discard the row; pulse seq_err.
  - ACCUM, stage==2 and count==row_cnt: accept the row; row_cnt++. If count==7, tag it last and return to IDLE.
  - ACCUM, stage!=2, or count!=row_cnt: abort the block and pulse seq_err. Clear in-flight rows of this block from the pipeline so nothing reaches the accumulator.
  - Abort exception: if the violating row has count==0, accept it as first of a new block, row_cnt=1, stay in ACCUM.
- seq_err timing: pulses in cycle t+1 after the violating cycle t.
- Pipeline, for a row accepted in cycle t:
  - S1 (visible t+1): abs of each coefficient, COEF_W-bit unsigned. -2^(COEF_W-1) maps to 2^(COEF_W-1) with no saturation. Carries valid/first/last tags.
  - S2 (visible t+2): row_sum = sum of 8 abs values, COEF_W+3 bits, zero-extended.
  - S3 (edge ending t+2): if first, acc <= row_sum; else acc <= acc + row_sum. Arithmetic is ACC_W wide with no overflow possible at the parameter minimums.
  - If last: satd_out <= (acc_next + round) >> NORM_SHIFT, and satd_valid=1 during t+3 only.
- Latency: row 7 in cycle t gives satd_valid in cycle t+3. With the standard sequencer this coincides with the following stage-0 cycle.
- busy: rises in the cycle after the first row is accepted and falls in the satd_valid cycle.
- Back-to-back blocks: the standard sequencer period is 19 cycles. A new first row may enter S1 while the previous block's rows are still in S2/S3; per-row tags keep blocks separate.
- Non-stage-2 cycles carry no data; coef_in is ignored outside stage 2.

Test Plan:
- All 64 coefficients = +1 over stage 2 counts 0..7 -> satd_valid 3 cycles after count 7, satd_out = (64+2)>>2 = 16; seq_err never asserts.
- All coefficients = -1 -> satd_out = 16. Single coefficient = -32768 in row 3, all others 0 -> satd_out = (32768+2)>>2 = 8192.
- All coefficients = 32767 -> raw sum 2097088, satd_out = 524272; no wrap in the 22-bit accumulator.
- Two blocks driven by the real sequencer (19-cycle period): first block all +1, second all +2 -> satd_out 16 then 32, with satd_valid pulses exactly 19 cycles apart.
- Reset asserted during stage 2 count 4 -> no satd_valid and all outputs 0 the next cycle; a following full all-+1 block yields 16.
- Count sequence 0,1,2,5 in stage 2 -> seq_err pulse one cycle after count 5, no satd_valid, busy returns low. A later correct block yields the correct value.
